pc_next_unit: RTL and testbench

- Consumer of the instruction decoder's PCSrc/Branch_Type outputs.
- Holds the architectural PC.
- Resolves branches and jumps in ID and redirects fetch.
- Issues an IF flush on every redirect; keeps redirect/taken statistics and a halt detector for lab programs that end in a self-jump.

---
 rtl/cpu_defs.sv | 20 ++
 rtl/pc_next_unit_if.sv | 33 +++
 rtl/branch_cmp.sv | 29 ++
 rtl/pc_next_unit.sv | 107 ++++++++++
 tb/tb_pc_next_unit.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Encodings shared by the instruction decoder and the PC/next-PC logic, so both
// sides agree on the PCSrc and Branch_Type codes.
package cpu_defs;

   localparam logic [1:0] PCSRC_PC4    = 2'b00;
   localparam logic [1:0] PCSRC_JUMP   = 2'b01;
   localparam logic [1:0] PCSRC_JUMPR  = 2'b10;
   localparam logic [1:0] PCSRC_BRANCH = 2'b11;

   localparam logic [2:0] BT_NONE = 3'b000;
   localparam logic [2:0] BT_BNE  = 3'b001;
   localparam logic [2:0] BT_BLEZ = 3'b010;
   localparam logic [2:0] BT_BGTZ = 3'b011;
   localparam logic [2:0] BT_BLTZ = 3'b100;
   localparam logic [2:0] BT_BEQ  = 3'b101;

   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
   localparam int          CNT_W_DEFAULT    = 16;

endpackage

// File: rtl/pc_next_unit_if.sv
// ID-stage to PC-unit bundle: resolved control/operands in, fetch PC and status out.
interface pc_next_unit_if #(
   parameter int CNT_W = cpu_defs::CNT_W_DEFAULT
);
   logic             stall;
   logic             id_valid;
   logic [31:0]      id_pc_plus4;
   logic [1:0]       PCSrc;
   logic [2:0]       Branch_Type;
   logic [31:0]      rs_data;
   logic [31:0]      rt_data;
   logic [31:0]      imm_ext;
   logic [25:0]      instr_index;
   logic [31:0]      pc;
   logic [31:0]      pc_plus4;
   logic             flush_if;
   logic             halted;
   logic             align_err;
   logic [CNT_W-1:0] redirect_cnt;
   logic [CNT_W-1:0] branch_cnt;

   modport master (
      output stall, id_valid, id_pc_plus4, PCSrc, Branch_Type,
             rs_data, rt_data, imm_ext, instr_index,
      input  pc, pc_plus4, flush_if, halted, align_err, redirect_cnt, branch_cnt
   );

   modport slave (
      input  stall, id_valid, id_pc_plus4, PCSrc, Branch_Type,
             rs_data, rt_data, imm_ext, instr_index,
      output pc, pc_plus4, flush_if, halted, align_err, redirect_cnt, branch_cnt
   );
endinterface

// File: rtl/branch_cmp.sv
// Branch condition evaluation on forwarded operands; rs/rt are treated as signed.
module branch_cmp
   import cpu_defs::*;
(
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic [2:0]  branch_type,
   output logic        taken
);

   logic rs_zero;
   logic rs_neg;

   assign rs_zero = (rs_data == 32'd0);
   assign rs_neg  = rs_data[31];

   always_comb begin
      taken = 1'b0;
      case (branch_type)
         BT_BEQ:  taken = (rs_data == rt_data);
         BT_BNE:  taken = (rs_data != rt_data);
         BT_BLEZ: taken = rs_neg | rs_zero;
         BT_BGTZ: taken = !rs_neg && !rs_zero;
         BT_BLTZ: taken = rs_neg;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_next_unit.sv
// Architectural PC with ID-stage branch/jump resolution, IF flush, redirect
// statistics and a self-jump halt detector.
module pc_next_unit
   import cpu_defs::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
   parameter int          CNT_W    = CNT_W_DEFAULT
)(
   input  logic           clk,
   input  logic           reset,
   pc_next_unit_if.slave  bus
);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

   state_e           state_reg;
   logic [31:0]      pc_reg;
   logic [31:0]      pc_next;
   logic             halted_reg;
   logic             align_err_reg;
   logic [CNT_W-1:0] redirect_cnt_reg;
   logic [CNT_W-1:0] branch_cnt_reg;

   logic             taken;
   logic             run;
   logic             is_branch;
   logic             redirect;
   logic             redirect_go;
   logic             self_jump;
   logic             misaligned;
   logic [31:0]      target;

   // The comparator output is only consulted when PCSrc selects a branch; the
   // decoder puts BEQ's code on Branch_Type for every non-branch.
   branch_cmp u_branch_cmp (
      .rs_data     (bus.rs_data),
      .rt_data     (bus.rt_data),
      .branch_type (bus.Branch_Type),
      .taken       (taken)
   );

   assign run       = (state_reg == RUN);
   assign is_branch = (bus.PCSrc == PCSRC_BRANCH);

   always_comb begin
      target = bus.id_pc_plus4 + (bus.imm_ext << 2);
      case (bus.PCSrc)
         PCSRC_JUMP:  target = {bus.id_pc_plus4[31:28], bus.instr_index, 2'b00};
         PCSRC_JUMPR: target = {bus.rs_data[31:2], 2'b00};
         default:     target = bus.id_pc_plus4 + (bus.imm_ext << 2);
      endcase
   end

   assign redirect    = bus.id_valid && run &&
                        ((bus.PCSrc == PCSRC_JUMP) || (bus.PCSrc == PCSRC_JUMPR) ||
                         (is_branch && taken));
   assign redirect_go = redirect && !bus.stall;
   assign self_jump   = (target == (bus.id_pc_plus4 - 32'd4));
   assign misaligned  = (bus.PCSrc == PCSRC_JUMPR) && (bus.rs_data[1:0] != 2'b00);

   always_comb begin
      pc_next = pc_reg + 32'd4;
      if (bus.stall || !run) begin
         pc_next = pc_reg;
      end else if (redirect) begin
         pc_next = target;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_reg           <= PC_RESET;
         state_reg        <= RUN;
         halted_reg       <= 1'b0;
         align_err_reg    <= 1'b0;
         redirect_cnt_reg <= '0;
         branch_cnt_reg   <= '0;
      end else begin
         pc_reg <= pc_next;
         if (!bus.stall && run) begin
            if (redirect && (redirect_cnt_reg != '1)) begin
               redirect_cnt_reg <= redirect_cnt_reg + CNT_W'(1);
            end
            if (bus.id_valid && is_branch && (branch_cnt_reg != '1)) begin
               branch_cnt_reg <= branch_cnt_reg + CNT_W'(1);
            end
            if (redirect && misaligned) begin
               align_err_reg <= 1'b1;
            end
            // A self-targeting redirect still loads its target, then parks there.
            if (redirect && self_jump) begin
               state_reg  <= HALT;
               halted_reg <= 1'b1;
            end
         end
      end
   end

   assign bus.pc           = pc_reg;
   assign bus.pc_plus4     = pc_reg + 32'd4;
   assign bus.flush_if     = redirect_go && !reset;
   assign bus.halted       = halted_reg;
   assign bus.align_err    = align_err_reg;
   assign bus.redirect_cnt = redirect_cnt_reg;
   assign bus.branch_cnt   = branch_cnt_reg;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: expected next-PC values are queued when the
// ID-stage stimulus is applied and compared after the following clock edge.
module tb_pc_next_unit;
   import cpu_defs::*;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;
   exp_t sb[$];

   pc_next_unit_if #(.CNT_W(16)) bus ();

   pc_next_unit #(
      .PC_RESET (32'h0000_0000),
      .CNT_W    (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("ok   %s: %h", tag, got);
      end else begin
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic valid, input logic [1:0] pcsrc, input logic [2:0] bt,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] pc4,
                        input logic [31:0] imm, input logic [25:0] idx);
      bus.id_valid    = valid;
      bus.PCSrc       = pcsrc;
      bus.Branch_Type = bt;
      bus.rs_data     = rs;
      bus.rt_data     = rt;
      bus.id_pc_plus4 = pc4;
      bus.imm_ext     = imm;
      bus.instr_index = idx;
   endtask

   task automatic idle();
      drive(1'b0, PCSRC_PC4, BT_BEQ, 32'd0, 32'd0, 32'd0, 32'd0, 26'd0);
   endtask

   // Called at a falling edge with inputs already applied.
   task automatic step(input logic exp_flush, input logic [31:0] exp_pc, input string tag);
      exp_t e;
      #1;
      check_val({tag, "_flush"}, 32'(bus.flush_if), 32'(exp_flush));
      e.tag = {tag, "_pc"};
      e.val = exp_pc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_val(e.tag, bus.pc, e.val);
      @(negedge clk);
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      reset     = 1'b1;
      bus.stall = 1'b0;
      // A jump presented during reset must not flush.
      drive(1'b1, PCSRC_JUMP, BT_BEQ, 32'd0, 32'd0, 32'h100, 32'd0, 26'h40);
      @(negedge clk);
      @(negedge clk);
      check_val("rst_flush", 32'(bus.flush_if), 32'd0);
      check_val("rst_pc", bus.pc, 32'h0);
      check_val("rst_halted", 32'(bus.halted), 32'd0);
      check_val("rst_align", 32'(bus.align_err), 32'd0);
      check_val("rst_rcnt", 32'(bus.redirect_cnt), 32'd0);
      check_val("rst_bcnt", 32'(bus.branch_cnt), 32'd0);
      idle();
      reset = 1'b0;
      check_val("rst_pc4", bus.pc_plus4, 32'h4);

      for (int i = 1; i <= 3; i++) step(1'b0, 32'(4 * i), "free");
      check_val("free_rcnt", 32'(bus.redirect_cnt), 32'd0);
      check_val("free_bcnt", 32'(bus.branch_cnt), 32'd0);

      drive(1'b1, PCSRC_BRANCH, BT_BEQ, 32'd5, 32'd5, 32'h20, 32'hFFFF_FFFE, 26'd0);
      step(1'b1, 32'h18, "beq");
      check_val("beq_rcnt", 32'(bus.redirect_cnt), 32'd1);
      check_val("beq_bcnt", 32'(bus.branch_cnt), 32'd1);

      drive(1'b1, PCSRC_BRANCH, BT_BGTZ, 32'd0, 32'd0, 32'h40, 32'd4, 26'd0);
      step(1'b0, 32'h1C, "bgtz");
      check_val("bgtz_rcnt", 32'(bus.redirect_cnt), 32'd1);
      check_val("bgtz_bcnt", 32'(bus.branch_cnt), 32'd2);

      drive(1'b1, PCSRC_BRANCH, BT_BLTZ, 32'h8000_0000, 32'd0, 32'h40, 32'd4, 26'd0);
      step(1'b1, 32'h50, "bltz");

      drive(1'b1, PCSRC_BRANCH, 3'b111, 32'd0, 32'd0, 32'h40, 32'd4, 26'd0);
      step(1'b0, 32'h54, "bt111");

      drive(1'b1, PCSRC_BRANCH, BT_BNE, 32'd1, 32'd2, 32'h100, 32'h10, 26'd0);
      step(1'b1, 32'h140, "bne");

      drive(1'b1, PCSRC_BRANCH, BT_BLEZ, 32'd0, 32'd9, 32'h200, 32'd1, 26'd0);
      step(1'b1, 32'h204, "blez");

      drive(1'b0, PCSRC_BRANCH, BT_BEQ, 32'd3, 32'd3, 32'h300, 32'd8, 26'd0);
      step(1'b0, 32'h208, "bubble");
      check_val("br_rcnt", 32'(bus.redirect_cnt), 32'd4);
      check_val("br_bcnt", 32'(bus.branch_cnt), 32'd6);

      drive(1'b1, PCSRC_JUMPR, BT_BEQ, 32'h1003, 32'd0, 32'h300, 32'd0, 26'd0);
      step(1'b1, 32'h1000, "jr");
      check_val("jr_align", 32'(bus.align_err), 32'd1);
      idle();
      for (int i = 1; i <= 10; i++) step(1'b0, 32'h1000 + 32'(4 * i), "post_jr");
      check_val("jr_align_sticky", 32'(bus.align_err), 32'd1);
      check_val("jr_rcnt", 32'(bus.redirect_cnt), 32'd5);

      bus.stall = 1'b1;
      drive(1'b1, PCSRC_JUMP, BT_BEQ, 32'd0, 32'd0, 32'h3000_0010, 32'd0, 26'h123456);
      step(1'b0, 32'h1028, "stall1");
      step(1'b0, 32'h1028, "stall2");
      check_val("stall_rcnt", 32'(bus.redirect_cnt), 32'd5);
      bus.stall = 1'b0;
      step(1'b1, 32'h3048_D158, "j_release");
      check_val("j_rcnt", 32'(bus.redirect_cnt), 32'd6);

      drive(1'b1, PCSRC_PC4, BT_BEQ, 32'd7, 32'd7, 32'h500, 32'd4, 26'd0);
      step(1'b0, 32'h3048_D15C, "nonbr");
      check_val("nonbr_bcnt", 32'(bus.branch_cnt), 32'd6);

      drive(1'b1, PCSRC_JUMP, BT_BEQ, 32'd0, 32'd0, 32'h44, 32'd0, 26'h10);
      step(1'b1, 32'h40, "selfj");
      check_val("selfj_halted", 32'(bus.halted), 32'd1);
      for (int i = 0; i < 20; i++) step(1'b0, 32'h40, "halt");
      check_val("halt_rcnt", 32'(bus.redirect_cnt), 32'd7);
      check_val("halt_halted", 32'(bus.halted), 32'd1);

      #2;
      reset = 1'b1;
      #1;
      check_val("arst_pc", bus.pc, 32'h0);
      check_val("arst_halted", 32'(bus.halted), 32'd0);
      check_val("arst_align", 32'(bus.align_err), 32'd0);
      check_val("arst_rcnt", 32'(bus.redirect_cnt), 32'd0);
      check_val("arst_flush", 32'(bus.flush_if), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      drive(1'b1, PCSRC_JUMPR, BT_BEQ, 32'hFFFF_FFFC, 32'd0, 32'h8, 32'd0, 26'd0);
      step(1'b1, 32'hFFFF_FFFC, "jr_top");
      check_val("top_pc4", bus.pc_plus4, 32'h0);
      check_val("top_align", 32'(bus.align_err), 32'd0);
      idle();
      step(1'b0, 32'h0, "wrap");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
